// File: rtl/av_mailbox_if.sv
// Avalon-MM responder bus plus the FIFO drain stream and interrupt of the MCU mailbox.
// Revision: 1.0
`default_nettype none

interface av_mailbox_if;
  logic [15:0] av_address;
  logic        av_write;
  logic        av_read;
  logic [15:0] av_writedata;
  logic [15:0] av_readdata;
  logic        av_waitrequest;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        irq;

  modport master (
    output av_address, av_write, av_read, av_writedata, out_ready,
    input  av_readdata, av_waitrequest, out_data, out_valid, irq
  );

  modport slave (
    input  av_address, av_write, av_read, av_writedata, out_ready,
    output av_readdata, av_waitrequest, out_data, out_valid, irq
  );
endinterface

`default_nettype wire

// File: rtl/av_mailbox_slave.sv
// Avalon-MM mailbox slave: DATA writes feed a FIFO drained by valid/ready, with STATUS/CONTROL/THRESH and a level irq.
// Revision: 1.0
`default_nettype none

module av_mailbox_slave #(
  parameter int DEPTH         = 16,
  parameter bit BLOCK_ON_FULL = 1'b1
) (
  input  logic          sysclk,
  input  logic          sysreset_n,
  av_mailbox_if.slave   bus
);

  localparam int         PW      = $clog2(DEPTH);
  localparam logic [8:0] DEPTH_C = 9'(DEPTH);

  logic [15:0]   mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [8:0]    count;
  logic [8:0]    count_next;
  logic [8:0]    thresh;
  logic          ovf;
  logic          rd_pending;
  logic [15:0]   readdata_q;
  logic          irq_q;

  logic [1:0]    addr;
  logic          full;
  logic          empty;
  logic          wr_en;
  logic          data_wr;
  logic          push;
  logic          drop;
  logic          pop;
  logic          flush;
  logic          ovf_clr;
  logic          thresh_wr;
  logic [15:0]   head;
  logic [15:0]   rd_mux;
  logic          waitreq;
  logic          unused_bits;

  assign unused_bits = ^{bus.av_address[15:2], bus.av_writedata[15:9]};

  always_comb begin
    addr      = bus.av_address[1:0];
    full      = (count == DEPTH_C);
    empty     = (count == 9'd0);
    // A simultaneous read wins; the write half of an illegal read+write is dropped.
    wr_en     = bus.av_write && !bus.av_read;
    data_wr   = wr_en && (addr == 2'd0);
    push      = data_wr && !full;
    drop      = data_wr && full && !BLOCK_ON_FULL;
    flush     = wr_en && (addr == 2'd2) && bus.av_writedata[0];
    ovf_clr   = wr_en && (addr == 2'd2) && bus.av_writedata[1];
    thresh_wr = wr_en && (addr == 2'd3);
    pop       = !empty && bus.out_ready && !flush;

    if (flush) begin
      count_next = 9'd0;
    end else begin
      count_next = count + 9'(push) - 9'(pop);
    end

    head = empty ? 16'h0000 : mem[rd_ptr];

    case (addr)
      2'd0:    rd_mux = head;
      2'd1:    rd_mux = {ovf, full, empty, 4'b0000, count};
      2'd2:    rd_mux = 16'h0000;
      default: rd_mux = {7'b0000000, thresh};
    endcase

    if (bus.av_read) begin
      waitreq = !rd_pending;
    end else begin
      waitreq = data_wr && full && BLOCK_ON_FULL;
    end
  end

  always_ff @(posedge sysclk) begin
    if (!sysreset_n) begin
      count      <= 9'd0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      ovf        <= 1'b0;
      thresh     <= 9'd0;
      rd_pending <= 1'b0;
      readdata_q <= 16'h0000;
      irq_q      <= 1'b0;
    end else begin
      count <= count_next;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end

      if (drop) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end

      if (thresh_wr) thresh <= bus.av_writedata[8:0];

      irq_q <= (thresh != 9'd0) && (count_next >= thresh);

      // Fixed two-cycle read: capture on the stalled cycle, complete on the next.
      if (bus.av_read && !rd_pending) begin
        rd_pending <= 1'b1;
        readdata_q <= rd_mux;
      end else begin
        rd_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (push) mem[wr_ptr] <= bus.av_writedata;
  end

  assign bus.av_readdata    = readdata_q;
  assign bus.av_waitrequest = waitreq;
  assign bus.out_data       = head;
  assign bus.out_valid      = !empty;
  assign bus.irq            = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_av_mailbox_slave.sv
// Directed bench for av_mailbox_slave: one blocking and one dropping instance, selected per scenario.
// Revision: 1.0
`default_nettype none

module tb_av_mailbox_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic [15:0] address = '0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [15:0] writedata = '0;
  logic        out_ready = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  av_mailbox_if if_b ();
  av_mailbox_if if_d ();

  assign if_b.av_address   = address;
  assign if_b.av_write     = write;
  assign if_b.av_read      = read;
  assign if_b.av_writedata = writedata;
  assign if_b.out_ready    = out_ready;
  assign if_d.av_address   = address;
  assign if_d.av_write     = write;
  assign if_d.av_read      = read;
  assign if_d.av_writedata = writedata;
  assign if_d.out_ready    = out_ready;

  av_mailbox_slave #(.DEPTH(16), .BLOCK_ON_FULL(1'b1)) dut_block (
    .sysclk(clk), .sysreset_n(rst_n), .bus(if_b)
  );
  av_mailbox_slave #(.DEPTH(16), .BLOCK_ON_FULL(1'b0)) dut_drop (
    .sysclk(clk), .sysreset_n(rst_n), .bus(if_d)
  );

  // sel=0 observes the blocking instance, sel=1 the dropping one.
  logic        waitreq;
  logic [15:0] readdata;
  logic [15:0] out_data;
  logic        out_valid;
  logic        irq;
  assign waitreq   = sel ? if_d.av_waitrequest : if_b.av_waitrequest;
  assign readdata  = sel ? if_d.av_readdata    : if_b.av_readdata;
  assign out_data  = sel ? if_d.out_data       : if_b.out_data;
  assign out_valid = sel ? if_d.out_valid      : if_b.out_valid;
  assign irq       = sel ? if_d.irq            : if_b.irq;

  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0;
    write = 1'b0;
    read = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d, output int stalls);
    @(posedge clk);
    #1;
    address = a;
    writedata = d;
    write = 1'b1;
    stalls = 0;
    @(negedge clk);
    while (waitreq && stalls < 40) begin
      stalls++;
      @(negedge clk);
    end
    if (waitreq) begin
      n_checks++;
      n_fail++;
      $display("FAIL write_timeout addr=%h: waitrequest still 1, required 0", a);
    end
    @(posedge clk);
    #1;
    write = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d, output int stalls);
    @(posedge clk);
    #1;
    address = a;
    read = 1'b1;
    stalls = 0;
    @(negedge clk);
    while (waitreq && stalls < 40) begin
      stalls++;
      @(negedge clk);
    end
    if (waitreq) begin
      n_checks++;
      n_fail++;
      $display("FAIL read_timeout addr=%h: waitrequest still 1, required 0", a);
    end
    d = readdata;
    @(posedge clk);
    #1;
    read = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    int st;
    sel = 1'b0;
    do_reset();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%b exp=0", irq); end
    n_checks++;
    if (readdata !== 16'h0000) begin n_fail++; $display("FAIL reset_readdata got=%h exp=0000", readdata); end
    n_checks++;
    if (waitreq !== 1'b0) begin n_fail++; $display("FAIL reset_waitreq got=%b exp=0", waitreq); end
    bus_read(16'h0001, d, st);
    n_checks++;
    if (st !== 1) begin n_fail++; $display("FAIL reset_read_latency got=%0d exp=1", st); end
    n_checks++;
    if (d !== 16'h2000) begin n_fail++; $display("FAIL reset_status got=%h exp=2000", d); end
  endtask

  task automatic test_push_drain();
    logic [15:0] d;
    int st;
    sel = 1'b0;
    do_reset();
    bus_write(16'h0000, 16'hA5A5, st);
    bus_write(16'h0000, 16'h1234, st);
    bus_read(16'h0001, d, st);
    n_checks++;
    if (d !== 16'h0002) begin n_fail++; $display("FAIL push_status got=%h exp=0002", d); end
    bus_read(16'h0000, d, st);
    n_checks++;
    if (d !== 16'hA5A5) begin n_fail++; $display("FAIL data_peek got=%h exp=a5a5", d); end
    @(negedge clk);
    n_checks++;
    if (out_data !== 16'hA5A5 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL drain_first got=%h/%b exp=a5a5/1", out_data, out_valid);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_data !== 16'h1234 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL drain_second got=%h/%b exp=1234/1", out_data, out_valid);
    end
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_block_on_full();
    logic [15:0] d;
    int st;
    sel = 1'b0;
    do_reset();
    for (int i = 0; i < 16; i++) bus_write(16'h0000, 16'h0100 + 16'(i), st);
    bus_read(16'h0001, d, st);
    n_checks++;
    if (d !== 16'h4010) begin n_fail++; $display("FAIL full_status got=%h exp=4010", d); end
    @(posedge clk);
    #1;
    address = 16'h0000;
    writedata = 16'h0117;
    write = 1'b1;
    @(negedge clk);
    n_checks++;
    if (waitreq !== 1'b1) begin n_fail++; $display("FAIL block_stall got=%b exp=1", waitreq); end
    @(negedge clk);
    n_checks++;
    if (waitreq !== 1'b1) begin n_fail++; $display("FAIL block_stall_hold got=%b exp=1", waitreq); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (waitreq !== 1'b0) begin n_fail++; $display("FAIL block_release got=%b exp=0", waitreq); end
    n_checks++;
    if (out_data !== 16'h0101) begin n_fail++; $display("FAIL block_head got=%h exp=0101", out_data); end
    @(posedge clk);
    #1;
    write = 1'b0;
    bus_read(16'h0001, d, st);
    n_checks++;
    if (d !== 16'h4010) begin n_fail++; $display("FAIL block_refill_status got=%h exp=4010", d); end
  endtask

  task automatic test_drop_on_full();
    logic [15:0] d;
    int st;
    sel = 1'b1;
    do_reset();
    for (int i = 0; i < 16; i++) bus_write(16'h0000, 16'h0200 + 16'(i), st);
    bus_write(16'h0000, 16'hBEEF, st);
    n_checks++;
    if (st !== 0) begin n_fail++; $display("FAIL drop_no_stall got=%0d exp=0", st); end
    bus_read(16'h0001, d, st);
    n_checks++;
    if (d !== 16'hC010) begin n_fail++; $display("FAIL drop_status got=%h exp=c010", d); end
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (out_data !== 16'h0200 + 16'(i) || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL drop_drain[%0d] got=%h/%b exp=%h/1", i, out_data, out_valid, 16'h0200 + 16'(i));
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drop_beef_absent got=%b/%h exp=0", out_valid, out_data); end
    bus_write(16'h0002, 16'h0002, st);
    bus_read(16'h0001, d, st);
    n_checks++;
    if (d !== 16'h2000) begin n_fail++; $display("FAIL ovf_clear got=%h exp=2000", d); end
  endtask

  task automatic test_irq();
    logic [15:0] d;
    int st;
    sel = 1'b0;
    do_reset();
    bus_write(16'h0003, 16'h0004, st);
    bus_read(16'h0003, d, st);
    n_checks++;
    if (d !== 16'h0004) begin n_fail++; $display("FAIL thresh_read got=%h exp=0004", d); end
    for (int i = 0; i < 3; i++) bus_write(16'h0000, 16'h0300 + 16'(i), st);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_below got=%b exp=0", irq); end
    bus_write(16'h0000, 16'h0303, st);
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_rise got=%b exp=1", irq); end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_fall got=%b exp=0", irq); end
  endtask

  task automatic test_flush_and_reset_read();
    logic [15:0] d;
    int st;
    sel = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) bus_write(16'h0000, 16'h0400 + 16'(i), st);
    @(posedge clk);
    #1;
    address = 16'h0002;
    writedata = 16'h0001;
    write = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    write = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
    bus_read(16'h0001, d, st);
    n_checks++;
    if (d !== 16'h2000) begin n_fail++; $display("FAIL flush_status got=%h exp=2000", d); end
    bus_write(16'h0000, 16'h0555, st);
    @(posedge clk);
    #1;
    address = 16'h0001;
    read = 1'b1;
    @(negedge clk);
    n_checks++;
    if (waitreq !== 1'b1) begin n_fail++; $display("FAIL rst_read_stall got=%b exp=1", waitreq); end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    read = 1'b0;
    rst_n = 1'b1;
    n_checks++;
    if (readdata !== 16'h0000) begin n_fail++; $display("FAIL rst_readdata got=%h exp=0000", readdata); end
    bus_read(16'h0001, d, st);
    n_checks++;
    if (st !== 1) begin n_fail++; $display("FAIL rst_no_stale got=%0d exp=1", st); end
    n_checks++;
    if (d !== 16'h2000) begin n_fail++; $display("FAIL rst_status got=%h exp=2000", d); end
  endtask

  initial begin
    test_reset();
    test_push_drain();
    test_block_on_full();
    test_drop_on_full();
    test_irq();
    test_flush_and_reset_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
